// File: rtl/regfile_mover_if.sv
// Command and register-file port bundle for regfile_mover.
// slave is the mover's view; master is the controller/register-file side.
interface regfile_mover_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_mode;
  logic [ADDR_WIDTH-1:0] cmd_src;
  logic [ADDR_WIDTH-1:0] cmd_dst;
  logic [ADDR_WIDTH:0]   cmd_count;
  logic [DATA_WIDTH-1:0] cmd_fill;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] rf_address;
  logic [DATA_WIDTH-1:0] rf_data_in;
  logic                  rf_enable;
  logic [DATA_WIDTH-1:0] rf_data_out;

  modport slave (
    input  cmd_valid, cmd_mode, cmd_src, cmd_dst, cmd_count, cmd_fill, rf_data_out,
    output cmd_ready, busy, done, rf_address, rf_data_in, rf_enable
  );

  modport master (
    output cmd_valid, cmd_mode, cmd_src, cmd_dst, cmd_count, cmd_fill, rf_data_out,
    input  cmd_ready, busy, done, rf_address, rf_data_in, rf_enable
  );
endinterface

// File: rtl/regfile_mover.sv
// Block COPY/FILL engine driving the 32x8 register file port.
// COPY costs RD/CAP/WR per element; FILL writes one element per cycle.
module regfile_mover #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input logic            clk,
  input logic            reset,
  regfile_mover_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH:0]   MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   REM_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   REM_ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH:0]   r_remaining, w_remaining_nxt;
  logic [ADDR_WIDTH-1:0] r_cur_src, w_cur_src_nxt;
  logic [ADDR_WIDTH-1:0] r_cur_dst, w_cur_dst_nxt;
  logic [DATA_WIDTH-1:0] r_fill, w_fill_nxt;
  logic [DATA_WIDTH-1:0] r_hold, w_hold_nxt;
  logic                  r_mode, w_mode_nxt;
  logic [ADDR_WIDTH-1:0] r_rf_address, w_rf_address_nxt;
  logic [DATA_WIDTH-1:0] r_rf_data_in, w_rf_data_in_nxt;
  logic                  r_rf_enable, w_rf_enable_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic                  w_accept;
  logic [ADDR_WIDTH:0]   w_count_clamped;

  assign w_accept        = bus.cmd_valid && (r_state == S_IDLE);
  assign w_count_clamped = (bus.cmd_count > MAX_COUNT) ? MAX_COUNT : bus.cmd_count;

  assign bus.cmd_ready  = (r_state == S_IDLE);
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.rf_address = r_rf_address;
  assign bus.rf_data_in = r_rf_data_in;
  assign bus.rf_enable  = r_rf_enable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Reset drops rf_enable asynchronously so a pending negedge write is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_remaining  <= {(ADDR_WIDTH+1){1'b0}};
      r_cur_src    <= {ADDR_WIDTH{1'b0}};
      r_cur_dst    <= {ADDR_WIDTH{1'b0}};
      r_fill       <= {DATA_WIDTH{1'b0}};
      r_hold       <= {DATA_WIDTH{1'b0}};
      r_mode       <= 1'b0;
      r_rf_address <= {ADDR_WIDTH{1'b0}};
      r_rf_data_in <= {DATA_WIDTH{1'b0}};
      r_rf_enable  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_remaining  <= w_remaining_nxt;
      r_cur_src    <= w_cur_src_nxt;
      r_cur_dst    <= w_cur_dst_nxt;
      r_fill       <= w_fill_nxt;
      r_hold       <= w_hold_nxt;
      r_mode       <= w_mode_nxt;
      r_rf_address <= w_rf_address_nxt;
      r_rf_data_in <= w_rf_data_in_nxt;
      r_rf_enable  <= w_rf_enable_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_remaining_nxt  = r_remaining;
    w_cur_src_nxt    = r_cur_src;
    w_cur_dst_nxt    = r_cur_dst;
    w_fill_nxt       = r_fill;
    w_hold_nxt       = r_hold;
    w_mode_nxt       = r_mode;
    w_rf_address_nxt = r_rf_address;
    w_rf_data_in_nxt = r_rf_data_in;
    w_rf_enable_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_mode_nxt      = bus.cmd_mode;
          w_cur_src_nxt   = bus.cmd_src;
          w_cur_dst_nxt   = bus.cmd_dst;
          w_fill_nxt      = bus.cmd_fill;
          w_remaining_nxt = w_count_clamped;
          w_hold_nxt      = {DATA_WIDTH{1'b0}};
          if (w_count_clamped == REM_ZERO) begin
            w_state_nxt = S_DONE;
          end else if (bus.cmd_mode == 1'b0) begin
            w_state_nxt      = S_RD;
            w_rf_address_nxt = bus.cmd_src;
          end else begin
            w_state_nxt      = S_WR;
            w_rf_address_nxt = bus.cmd_dst;
            w_rf_data_in_nxt = bus.cmd_fill;
            w_rf_enable_nxt  = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD: begin
        w_state_nxt = S_CAP;
      end
      S_CAP: begin
        // The file registered cur_src at the RD exit edge; its data is valid now.
        w_hold_nxt       = bus.rf_data_out;
        w_rf_data_in_nxt = bus.rf_data_out;
        w_rf_address_nxt = r_cur_dst;
        w_rf_enable_nxt  = 1'b1;
        w_state_nxt      = S_WR;
      end
      S_WR: begin
        w_remaining_nxt = r_remaining - REM_ONE;
        w_cur_src_nxt   = r_cur_src + ADDR_ONE;
        w_cur_dst_nxt   = r_cur_dst + ADDR_ONE;
        if (r_remaining == REM_ONE) begin
          w_state_nxt = S_DONE;
        end else if (r_mode == 1'b0) begin
          w_state_nxt      = S_RD;
          w_rf_address_nxt = r_cur_src + ADDR_ONE;
        end else begin
          w_state_nxt      = S_WR;
          w_rf_address_nxt = r_cur_dst + ADDR_ONE;
          w_rf_data_in_nxt = r_fill;
          w_rf_enable_nxt  = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

endmodule
